uart_tx_fifo_param: RTL and testbench

//  Parametrised UART transmitter, successor to the fixed 8N1 one-bit-per-clock transmitter.
//  - Adds an internal baud-rate divider, configurable frame format and a TX FIFO.
//  - Sits between on-chip producers (ready/valid) and the board serial TX pin.
//  - Lets software queue bursts of bytes without polling between characters.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo_param.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and elaboration-time helpers shared by the UART blocks.
//   tx_state_t    : transmitter frame state
//   params_legal  : returns 1 when a parameter set is supported
//   frame_clks    : clock cycles in one serial frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic bit params_legal(input int cpb, input int db, input int sb,
                                      input int depth, input int podd);
    return (cpb >= 2) && (db >= 5) && (db <= 8) && ((sb == 1) || (sb == 2)) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           ((podd == 0) || (podd == 1));
  endfunction

  function automatic int frame_clks(input int cpb, input int db, input int sb, input int par);
    return (1 + db + par + sb) * cpb;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO used as the UART character queue.
//   clk, rst  : clock, asynchronous active-high reset (pointers and level only)
//   push, din : write din when push and not full
//   pop, dout : dout shows the head entry; pop advances it when not empty
//   full, empty, level : occupancy flags and count (0..DEPTH)
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push;
  logic              w_pop;

  // Guards live here so a caller cannot corrupt the queue by mistake.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_level == LVL_FULL);
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: UART transmitter with baud divider, configurable frame
// format and a TX FIFO in front of the serialiser.
//   clk, rst   : clock, asynchronous active-high reset
//   tx_data    : word to send (LSB first), accepted when tx_valid & tx_ready
//   tx_valid   : producer has a word
//   tx_ready   : FIFO not full
//   tx         : registered serial output, idle high
//   busy       : frame in progress or words queued
//   fifo_level : current FIFO occupancy
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity when PARITY_ODD=0, odd when PARITY_ODD=1).
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (!params_legal(CLKS_PER_BIT, DATA_BITS, STOP_BITS, FIFO_DEPTH, PARITY_ODD)) begin : g_bad_params
    $error("uart_tx_fifo_param: unsupported parameter set");
  end

  tx_state_t                    r_state;
  tx_state_t                    w_state_next;
  logic [BAUD_W-1:0]            r_baud;
  logic [BIT_W-1:0]             r_bitcnt;
  logic [DATA_BITS-1:0]         r_shift;
  logic                         r_tx;
  logic                         w_tx_next;
  logic                         w_pop;
  logic                         w_bit_done;
  logic                         w_last_data;
  logic                         w_last_stop;
  logic [DATA_BITS-1:0]         w_fifo_dout;
  logic                         w_full;
  logic                         w_empty;
  logic [$clog2(FIFO_DEPTH):0]  w_level;
`ifdef UART_TX_PARITY_EN
  logic                         r_par;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction
`endif

  uart_sync_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  assign w_bit_done  = (r_baud == BAUD_LAST);
  assign w_last_data = (r_bitcnt == DATA_LAST);
  assign w_last_stop = (r_bitcnt == STOP_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (!w_empty) w_state_next = START;
      START: if (w_bit_done) w_state_next = DATA;
      DATA: begin
        if (w_bit_done && w_last_data) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_bit_done) w_state_next = STOP;
`endif
      STOP: begin
        // A queued word starts its frame with no idle bit in between.
        if (w_bit_done && w_last_stop) w_state_next = w_empty ? IDLE : START;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: line level for the next cycle and FIFO pop strobe
  always_comb begin
    w_tx_next = 1'b1;
    w_pop     = 1'b0;
    case (r_state)
      IDLE:  w_pop = !w_empty;
      START: w_tx_next = 1'b0;
      DATA:  w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: w_tx_next = r_par;
`endif
      STOP:  w_pop = w_bit_done && w_last_stop && !w_empty;
      default: w_tx_next = 1'b1;
    endcase
  end

  // Baud/bit counters and the output register. The bit counter restarts on
  // every state change so it indexes data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
      if ((r_state == IDLE) || w_bit_done) r_baud <= '0;
      else                                 r_baud <= r_baud + 1'b1;
      if (r_state != w_state_next) r_bitcnt <= '0;
      else if (w_bit_done)         r_bitcnt <= r_bitcnt + 1'b1;
    end
  end

  // Shift register: loaded on pop, shifted right at each data bit boundary.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
      r_par   <= parity_bit(w_fifo_dout);
`endif
    end else if ((r_state == DATA) && w_bit_done) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign tx         = r_tx;
  assign tx_ready   = !w_full;
  assign busy       = (r_state != IDLE) || (w_level != '0);
  assign fifo_level = w_level;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
module tb_uart_tx_fifo_param;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P_EN = 1;
`else
  localparam int P_EN = 0;
`endif
  // Instance A: 8 data bits, 1 stop, 4-deep FIFO, even parity.
  localparam int NB_A    = 1 + 8 + P_EN + 1;
  localparam int FRAME_A = NB_A * CPB;
  // Instance B: 5 data bits, 2 stop, 2-deep FIFO, odd parity.
  localparam int NB_B    = 1 + 5 + P_EN + 2;
  localparam int FRAME_B = NB_B * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data_a = '0;
  logic       tx_valid_a = 1'b0;
  logic       tx_ready_a, tx_a, busy_a;
  logic [2:0] lvl_a;
  logic [4:0] tx_data_b = '0;
  logic       tx_valid_b = 1'b0;
  logic       tx_ready_b, tx_b, busy_b;
  logic [1:0] lvl_b;

  int checks = 0;
  int failures = 0;
  int frames_a = 0;
  int frames_b = 0;
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [2:0] lvl_log[8];
  logic       rdy_log[8];

  always #5 clk = ~clk;

  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1),
                       .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a), .fifo_level(lvl_a));

  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2),
                       .FIFO_DEPTH(2), .PARITY_ODD(1)) u_dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b), .fifo_level(lvl_b));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Collapse line samples into one value per bit; bit 16 flags a bit whose
  // level changed within its CPB samples.
  function automatic logic [16:0] decode(input logic [63:0] s, input int nb);
    logic [16:0] r;
    r = '0;
    for (int k = 0; k < nb; k++) begin
      r[k] = s[k*CPB];
      for (int j = 1; j < CPB; j++)
        if (s[k*CPB+j] != s[k*CPB]) r[16] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [16:0] expect_frame(input logic [7:0] d, input int db,
                                               input int sb, input int podd);
    logic [16:0] r;
    int k;
    r = '0;
    r[0] = 1'b0;
    for (int i = 0; i < db; i++) r[1+i] = d[i];
    k = 1 + db;
    if (P_EN != 0) begin
      r[k] = (podd != 0) ? ~^d : ^d;
      k = k + 1;
    end
    for (int i = 0; i < sb; i++) r[k+i] = 1'b1;
    return r;
  endfunction

  initial begin : mon_a
    logic [63:0] s;
    int n;
    logic [7:0] e;
    logic [16:0] got;
    s = '0;
    n = 0;
    forever begin
      @(negedge clk);
      if (rst) n = 0;
      else if ((n > 0) || (tx_a == 1'b0)) begin
        s[n] = tx_a;
        n++;
        if (n == FRAME_A) begin
          n = 0;
          frames_a++;
          got = decode(s, NB_A);
          if (exp_q_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL frame_a unexpected frame bits=%0h", got);
          end else begin
            e = exp_q_a.pop_front();
            check("frame_a", 32'(got), 32'(expect_frame(e, 8, 1, 0)));
          end
        end
      end
    end
  end

  initial begin : mon_b
    logic [63:0] s;
    int n;
    logic [7:0] e;
    logic [16:0] got;
    s = '0;
    n = 0;
    forever begin
      @(negedge clk);
      if (rst) n = 0;
      else if ((n > 0) || (tx_b == 1'b0)) begin
        s[n] = tx_b;
        n++;
        if (n == FRAME_B) begin
          n = 0;
          frames_b++;
          got = decode(s, NB_B);
          if (exp_q_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL frame_b unexpected frame bits=%0h", got);
          end else begin
            e = exp_q_b.pop_front();
            check("frame_b", 32'(got), 32'(expect_frame(e, 5, 2, 1)));
          end
        end
      end
    end
  end

  // Holds tx_valid for n consecutive edges with data first, first+1, ...
  // Returns at the negedge after the last edge; lvl_log[i]/rdy_log[i] hold
  // the level/ready seen after edge i of the burst.
  task automatic burst_a(input logic [7:0] first, input int n, input bit keep, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        lvl_log[i-1] = lvl_a;
        rdy_log[i-1] = tx_ready_a;
      end
      tx_data_a  = first + 8'(i);
      tx_valid_a = 1'b1;
      if (tx_ready_a) begin
        acc++;
        if (keep) exp_q_a.push_back(first + 8'(i));
      end
    end
    @(negedge clk);
    lvl_log[n-1] = lvl_a;
    rdy_log[n-1] = tx_ready_a;
    tx_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] v);
    @(negedge clk);
    tx_data_b  = v[4:0];
    tx_valid_b = 1'b1;
    if (tx_ready_b) exp_q_b.push_back(v & 8'h1F);
    @(negedge clk);
    tx_valid_b = 1'b0;
  endtask

  // Counts negedge samples with busy high, starting with the current one.
  task automatic count_busy_a(output int c);
    c = 0;
    while (busy_a && (c < 2000)) begin
      c++;
      @(negedge clk);
    end
    if (busy_a) begin
      checks++; failures++;
      $display("FAIL busy_a_timeout cycles=%0d", c);
    end
  endtask

  task automatic count_busy_b(output int c);
    c = 0;
    while (busy_b && (c < 2000)) begin
      c++;
      @(negedge clk);
    end
    if (busy_b) begin
      checks++; failures++;
      $display("FAIL busy_b_timeout cycles=%0d", c);
    end
  endtask

  task automatic reset_mid(input logic [7:0] first, input int w, input logic pre_tx);
    int acc;
    int lows;
    burst_a(first, 3, 1'b0, acc);
    repeat (w) @(negedge clk);
    check("rst_pre_level", 32'(lvl_a), 32'd2);
    check("rst_pre_tx", 32'(tx_a), 32'(pre_tx));
    rst = 1'b1;
    #1;
    check("rst_tx_now", 32'(tx_a), 32'd1);
    check("rst_level_now", 32'(lvl_a), 32'd0);
    check("rst_busy_now", 32'(busy_a), 32'd0);
    check("rst_ready_now", 32'(tx_ready_a), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!tx_a) lows++;
    end
    check("rst_no_frame", 32'(lows), 32'd0);
    check("rst_level_after", 32'(lvl_a), 32'd0);
    check("rst_busy_after", 32'(busy_a), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    int c;
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_tx_a", 32'(tx_a), 32'd1);
    check("reset_ready_a", 32'(tx_ready_a), 32'd1);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_level_a", 32'(lvl_a), 32'd0);
    check("reset_tx_b", 32'(tx_b), 32'd1);
    check("reset_ready_b", 32'(tx_ready_b), 32'd1);
    check("reset_busy_b", 32'(busy_b), 32'd0);
    check("reset_level_b", 32'(lvl_b), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word 0xA5: pop one edge after the push, line low one edge later.
    burst_a(8'hA5, 1, 1'b1, acc);
    check("t1_level_after_push", 32'(lvl_a), 32'd1);
    check("t1_busy_after_push", 32'(busy_a), 32'd1);
    check("t1_tx_idle_at_push", 32'(tx_a), 32'd1);
    @(negedge clk);
    check("t1_level_after_pop", 32'(lvl_a), 32'd0);
    check("t1_tx_still_high", 32'(tx_a), 32'd1);
    @(negedge clk);
    check("t1_start_bit", 32'(tx_a), 32'd0);
    count_busy_a(c);
    // One cycle queued before the pop, then the frame.
    check("t1_busy_cycles", 32'(2 + c), 32'(1 + FRAME_A));

    burst_a(8'h07, 1, 1'b1, acc);
    count_busy_a(c);
    check("t1b_busy_cycles", 32'(c), 32'(1 + FRAME_A));

    // Three words on consecutive edges; the first edge after the first push
    // pops and pushes at once, so the level reads 1,1,2.
    burst_a(8'h01, 3, 1'b1, acc);
    check("t2_level0", 32'(lvl_log[0]), 32'd1);
    check("t2_level1", 32'(lvl_log[1]), 32'd1);
    check("t2_level2", 32'(lvl_log[2]), 32'd2);
    count_busy_a(c);
    check("t2_busy_cycles", 32'(2 + c), 32'(1 + 3 * FRAME_A));

    // Hold valid for 8 edges into a 4-deep FIFO.
    burst_a(8'h10, 8, 1'b1, acc);
    check("t3_accepted", 32'(acc), 32'd5);
    check("t3_ready_before_full", 32'(rdy_log[3]), 32'd1);
    check("t3_level_full", 32'(lvl_log[4]), 32'd4);
    check("t3_ready_full", 32'(rdy_log[4]), 32'd0);
    check("t3_level_held", 32'(lvl_log[7]), 32'd4);
    count_busy_a(c);
    check("t3_busy_cycles", 32'(7 + c), 32'(1 + 5 * FRAME_A));
    repeat (3) @(negedge clk);

    // Reset during the data bits of 0xFF, and during the start bit of 0x00.
    reset_mid(8'hFF, 12, 1'b1);
    reset_mid(8'h00, 2, 1'b0);

    // Instance B: upper bits of the input word are ignored.
    send_b(8'h1F);
    send_b(8'hE5);
    send_b(8'h0A);
    count_busy_b(c);
    check("t6_busy_cycles", 32'(4 + c), 32'(1 + 3 * FRAME_B));
    repeat (3) @(negedge clk);

    check("frames_a_seen", 32'(frames_a), 32'd10);
    check("frames_b_seen", 32'(frames_b), 32'd3);
    check("queue_a_drained", 32'(exp_q_a.size()), 32'd0);
    check("queue_b_drained", 32'(exp_q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
